// File: rtl/dff_mem_pkg.sv
// dff_mem_pkg: shared command opcodes and controller states for the burst RAM
package dff_mem_pkg;
  typedef enum logic [1:0] {OP_RD = 2'b00, OP_WR = 2'b01, OP_CLR = 2'b10, OP_RSV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_e;
endpackage

// File: rtl/dff_mem_array.sv
// dff_mem_array: flop storage with one synchronous write port and one combinational read port
module dff_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dff_ram_burst_ctrl.sv
// dff_ram_burst_ctrl: valid/ready burst read/write/clear controller around a flop RAM
module dff_ram_burst_ctrl
  import dff_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err
);
  state_e            state, nxt;
  op_e               op;
  logic [ADDR_W-1:0] ptr, ptr_inc;
  logic [LEN_W-1:0]  cnt;
  logic              hs, bad, wr_beat, rd_load, ptr_end, we;
  logic [DATA_W-1:0] wdata, rdata;

  assign op      = op_e'(req_op);
  assign hs      = req_valid & req_ready;
  assign bad     = op == OP_RSV || (op != OP_CLR && {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH));
  assign ptr_end = ptr == ADDR_W'(DEPTH - 1);
  assign ptr_inc = ptr_end ? '0 : ptr + 1'b1;
  assign wr_beat = state == WRITE && wr_valid;
  assign rd_load = state == READ && (!rd_valid || rd_ready);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = hs && !bad ? (op == OP_RD ? READ : op == OP_WR ? WRITE : CLEAR) : IDLE;
      WRITE: nxt = wr_beat && cnt == '0 ? IDLE : WRITE;
      READ:  nxt = rd_load && cnt == '0 ? IDLE : READ;
      CLEAR: nxt = ptr_end ? IDLE : CLEAR;
      default: nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst so it reads 0 while reset is held
  always_comb begin
    req_ready = state == IDLE && !rd_valid && !rst;
    wr_ready  = state == WRITE;
    we        = wr_beat || state == CLEAR;
    wdata     = state == CLEAR ? '0 : wr_data;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr      <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= state != IDLE && nxt == IDLE;
      err  <= hs && bad;
      if (hs) begin
        ptr <= op == OP_CLR ? '0 : req_addr;
        cnt <= req_len;
      end else if (we || rd_load) begin
        ptr <= ptr_inc;
        cnt <= cnt - 1'b1;
      end
      if (rd_load) begin
        rd_data  <= rdata;
        rd_valid <= 1'b1;
      end else if (rd_ready) rd_valid <= 1'b0;
    end

  dff_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(ptr),
    .wdata(wdata),
    .raddr(ptr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_dff_ram_burst_ctrl.sv
// tb_dff_ram_burst_ctrl: directed scoreboard bench for a DEPTH=16 and a DEPTH=12 controller
module tb_dff_ram_burst_ctrl;
  import dff_mem_pkg::*;
  logic clk = 1'b0, rst;
  logic req_valid, req_ready, wr_valid, wr_ready, rd_valid, rd_ready, done, err;
  logic [1:0] req_op;
  logic [3:0] req_addr, req_len;
  logic [7:0] wr_data, rd_data;
  logic s_req_valid, s_req_ready, s_wr_valid, s_wr_ready, s_rd_valid, s_done, s_err;
  logic [1:0] s_req_op;
  logic [3:0] s_req_addr, s_req_len;
  logic [7:0] s_wr_data, s_rd_data;
  logic c_req_ready, c_wr_ready, c_rd_valid, c_done, c_err;
  logic [7:0] c_rd_data;
  logic hs_req, hs_wr, done_q, err_q, last_done, hold_prev = 1'b0;
  logic [7:0] hold_data;
  logic [7:0] sb[$];
  logic [7:0] q[$];
  int checks = 0, passes = 0, n;

  dff_ram_burst_ctrl #(.DATA_W(8), .DEPTH(16), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err));

  dff_ram_burst_ctrl #(.DATA_W(8), .DEPTH(12), .LEN_W(4)) dut12 (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(s_req_op),
    .req_addr(s_req_addr), .req_len(s_req_len), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .wr_data(s_wr_data), .rd_valid(s_rd_valid), .rd_ready(1'b1), .rd_data(s_rd_data),
    .done(s_done), .err(s_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Samples everything mid-cycle, scoreboards consumed read beats, then crosses one rising edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    hs_req = req_valid && req_ready;
    hs_wr  = wr_valid && wr_ready;
    done_q = done;
    err_q  = err;
    if (hold_prev) begin
      chk("hold_valid", rd_valid, 1);
      chk("hold_data", rd_data, hold_data);
    end
    hold_prev = rd_valid && !rd_ready;
    hold_data = rd_data;
    if (rd_valid) chk("busy_req_ready", req_ready, 0);
    if (rd_valid && rd_ready) begin
      if (sb.size() == 0) chk("sb_extra_beat", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e);
        last_done = done;
      end
    end
    c_req_ready = s_req_ready;
    c_wr_ready  = s_wr_ready;
    c_rd_valid  = s_rd_valid;
    c_rd_data   = s_rd_data;
    c_done      = s_done;
    c_err       = s_err;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] len);
    req_op = op; req_addr = addr; req_len = len; req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (hs_req) break;
    end
    req_valid = 1'b0;
    chk("cmd_accepted", hs_req, 1);
  endtask

  task automatic wait_done(input string tag, input int lim, output int cyc);
    cyc = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      cyc++;
      if (done_q) break;
    end
    chk(tag, done_q, 1);
  endtask

  task automatic beat(input logic [7:0] d);
    wr_data = d; wr_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      if (hs_wr) break;
    end
    wr_valid = 1'b0;
    chk("wr_beat", hs_wr, 1);
  endtask

  task automatic write_burst(input logic [3:0] addr, input logic [7:0] d[$]);
    int c;
    do_cmd(OP_WR, addr, 4'(d.size() - 1));
    foreach (d[i]) beat(d[i]);
    wait_done("wr_done", 4, c);
    chk("wr_done_lat", c, 1);
  endtask

  task automatic read_burst(input logic [3:0] addr, input logic [3:0] len, input logic [31:0] pat,
                            input logic [7:0] exp[$], output int iters);
    logic dn = 1'b0;
    foreach (exp[i]) sb.push_back(exp[i]);
    rd_ready = 1'b1;
    do_cmd(OP_RD, addr, len);
    iters = 0;
    for (int i = 0; i < 100; i++) begin
      rd_ready = i < 32 ? pat[i] : 1'b1;
      step();
      iters++;
      if (done_q) dn = 1'b1;
      if (sb.size() == 0 && dn) break;
    end
    chk("rd_done", dn, 1);
    chk("sb_drained", sb.size(), 0);
    step();
    chk("rd_idle_valid", rd_valid, 0);
    chk("rd_idle_ready", req_ready, 1);
  endtask

  task automatic s_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] len);
    s_req_op = op; s_req_addr = addr; s_req_len = len; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    chk("s_req_ready", c_req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    {req_valid, wr_valid, rd_ready, s_req_valid, s_wr_valid} = '0;
    {req_op, req_addr, req_len, wr_data, s_req_op, s_req_addr, s_req_len, s_wr_data} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", req_ready, 1);

    do_cmd(OP_CLR, 4'd9, 4'd2);
    wait_done("clr_done", 40, n);
    chk("clr_cycles", n, 17);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'h00);
    read_burst(4'd0, 4'd15, '1, q, n);

    write_burst(4'd3, {8'hA1, 8'hB2, 8'hC3, 8'hD4});
    last_done = 1'b0;
    read_burst(4'd3, 4'd3, '1, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, n);
    chk("rd_throughput", n, 5);
    chk("done_with_last", last_done, 1);

    write_burst(4'd14, {8'h11, 8'h22, 8'h33, 8'h44});
    read_burst(4'd0, 4'd1, '1, {8'h33, 8'h44}, n);
    read_burst(4'd14, 4'd1, '1, {8'h11, 8'h22}, n);

    read_burst(4'd3, 4'd2, 32'hFFFF_FFF9, {8'hA1, 8'hB2, 8'hC3}, n);

    do_cmd(OP_WR, 4'd8, 4'd3);
    beat(8'h55);
    beat(8'h66);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_prev = 1'b0;
    read_burst(4'd8, 4'd1, '1, {8'h55, 8'h66}, n);

    s_cmd(OP_CLR, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (c_done) break;
    end
    chk("s_clr_done", c_done, 1);
    s_cmd(OP_WR, 4'd11, 4'd0);
    s_wr_data = 8'h5A; s_wr_valid = 1'b1;
    step();
    s_wr_valid = 1'b0;
    chk("s_wr_ready", c_wr_ready, 1);
    step();
    chk("s_wr_done", c_done, 1);
    foreach (q[i]) q[i] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      s_cmd(k == 0 ? OP_RSV : k == 1 ? OP_RD : OP_WR, k == 0 ? 4'd3 : k == 1 ? 4'd12 : 4'd15, 4'd1);
      step();
      chk("s_err_pulse", c_err, 1);
      chk("s_err_no_done", c_done, 0);
      chk("s_err_idle", c_req_ready, 1);
      chk("s_err_no_wr", c_wr_ready, 0);
      chk("s_err_no_rd", c_rd_valid, 0);
      step();
      chk("s_err_once", c_err, 0);
    end
    s_cmd(OP_RD, 4'd10, 4'd1);
    step();
    step();
    chk("s_rd_valid", c_rd_valid, 1);
    chk("s_rd_10", c_rd_data, 8'h00);
    step();
    chk("s_rd_11", c_rd_data, 8'h5A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
